// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared types, default widths and saturating increment for the bbox detector
package bbox_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LATCH  = 2'd2
  } state_t;

  localparam int DEF_X_W  = 11;
  localparam int DEF_Y_W  = 10;
  localparam int DEF_PC_W = 19;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bin_xy_counter.sv
// rtl/bin_xy_counter.sv - input sampling, vsync/href edge detect, saturating col/row counters (BBOX_BORDER_MASK_EN)
module bin_xy_counter
  import bbox_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int BORDER = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vsync,
  input  logic           href,
  input  logic           clken,
  input  logic           pix_bit,
  input  logic           clear,
  input  logic           active,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           vs_rise,
  output logic           vs_fall,
  output logic           pix_en
);

`ifdef BBOX_BORDER_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic vs_s_q, vs_s_d, vs_p_q, vs_p_d;
  logic hs_s_q, hs_s_d, hs_p_q, hs_p_d;
  logic ck_s_q, ck_s_d, bit_s_q, bit_s_d;
  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;
  logic hs_fall, in_border;

  assign vs_rise = vs_s_q & ~vs_p_q;
  assign vs_fall = ~vs_s_q & vs_p_q;
  assign hs_fall = ~hs_s_q & hs_p_q;

  assign in_border = (int'(col_q) < BORDER) || (int'(col_q) > IMG_W - 1 - BORDER) ||
                     (int'(row_q) < BORDER) || (int'(row_q) > IMG_H - 1 - BORDER);

  assign pix_en = hs_s_q & ck_s_q & bit_s_q & (~MASK_EN | ~in_border);
  assign col    = col_q;
  assign row    = row_q;

  // Sample the stream once, keep the previous sample for edges, advance coordinates
  always_comb begin
    vs_s_d  = vsync;
    hs_s_d  = href;
    ck_s_d  = clken;
    bit_s_d = pix_bit;
    vs_p_d  = vs_s_q;
    hs_p_d  = hs_s_q;
    col_d   = col_q;
    row_d   = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (active) begin
      if (hs_fall) begin
        col_d = '0;
        row_d = Y_W'(sat_inc(32'(row_q), 32'(IMG_H - 1)));
      end else if (hs_s_q && ck_s_q) begin
        col_d = X_W'(sat_inc(32'(col_q), 32'(IMG_W - 1)));
      end
    end
  end

  // vsync history resets high so a reset inside a frame never fakes a rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s_q  <= 1'b1;
      vs_p_q  <= 1'b1;
      hs_s_q  <= 1'b0;
      hs_p_q  <= 1'b0;
      ck_s_q  <= 1'b0;
      bit_s_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      vs_s_q  <= vs_s_d;
      vs_p_q  <= vs_p_d;
      hs_s_q  <= hs_s_d;
      hs_p_q  <= hs_p_d;
      ck_s_q  <= ck_s_d;
      bit_s_q <= bit_s_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/bin_bbox_detector.sv
// rtl/bin_bbox_detector.sv - per-frame foreground bounding box and pixel count (BBOX_BORDER_MASK_EN)
module bin_bbox_detector
  import bbox_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int MIN_PIX = 64,
  parameter int BORDER  = 4
) (
  input  logic            pixelclk,
  input  logic            rst,
  input  logic            en,
  input  logic            per_frame_vsync,
  input  logic            per_frame_href,
  input  logic            per_frame_clken,
  input  logic            per_img_Bit,
  output logic            bbox_valid,
  output logic            obj_found,
  output logic [X_W-1:0]  x_min,
  output logic [X_W-1:0]  x_max,
  output logic [Y_W-1:0]  y_min,
  output logic [Y_W-1:0]  y_max,
  output logic [PC_W-1:0] pix_cnt
);

  state_t state_q, state_d;
  logic [X_W-1:0]  col, xmin_q, xmin_d, xmax_q, xmax_d, x_min_q, x_min_d, x_max_q, x_max_d;
  logic [Y_W-1:0]  row, ymin_q, ymin_d, ymax_q, ymax_d, y_min_q, y_min_d, y_max_q, y_max_d;
  logic [PC_W-1:0] cnt_q, cnt_d, pix_cnt_q, pix_cnt_d;
  logic            bbox_valid_q, bbox_valid_d, obj_found_q, obj_found_d;
  logic            vs_rise, vs_fall, pix_en, frame_start, active;

  assign frame_start = (state_q == IDLE) && vs_rise && en;
  assign active      = (state_q == ACTIVE);

  bin_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .BORDER(BORDER)
  ) u_xy (
    .clk    (pixelclk),
    .rst    (rst),
    .vsync  (per_frame_vsync),
    .href   (per_frame_href),
    .clken  (per_frame_clken),
    .pix_bit(per_img_Bit),
    .clear  (frame_start),
    .active (active),
    .col    (col),
    .row    (row),
    .vs_rise(vs_rise),
    .vs_fall(vs_fall),
    .pix_en (pix_en)
  );

  // Frame FSM: state register
  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = ACTIVE;
      ACTIVE:  if (vs_fall) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM outputs: publish in LATCH, hold data otherwise
  always_comb begin
    bbox_valid_d = 1'b0;
    obj_found_d  = obj_found_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    pix_cnt_d    = pix_cnt_q;
    if (state_q == LATCH) begin
      bbox_valid_d = 1'b1;
      pix_cnt_d    = cnt_q;
      if (cnt_q >= PC_W'(MIN_PIX)) begin
        obj_found_d = 1'b1;
        x_min_d     = xmin_q;
        x_max_d     = xmax_q;
        y_min_d     = ymin_q;
        y_max_d     = ymax_q;
      end else begin
        obj_found_d = 1'b0;
        x_min_d     = '0;
        x_max_d     = '0;
        y_min_d     = '0;
        y_max_d     = '0;
      end
    end
  end

  // Accumulators: seed at frame start, widen the box and count on each foreground pixel
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (frame_start) begin
      xmin_d = X_W'(IMG_W - 1);
      xmax_d = '0;
      ymin_d = Y_W'(IMG_H - 1);
      ymax_d = '0;
      cnt_d  = '0;
    end else if (active && pix_en) begin
      if (col < xmin_q) xmin_d = col;
      if (col > xmax_q) xmax_d = col;
      if (row < ymin_q) ymin_d = row;
      if (row > ymax_q) ymax_d = row;
      cnt_d = PC_W'(sat_inc(32'(cnt_q), 32'({PC_W{1'b1}})));
    end
  end

  // Accumulator and result registers
  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) begin
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      cnt_q        <= '0;
      bbox_valid_q <= 1'b0;
      obj_found_q  <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      pix_cnt_q    <= '0;
    end else begin
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cnt_q        <= cnt_d;
      bbox_valid_q <= bbox_valid_d;
      obj_found_q  <= obj_found_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  assign bbox_valid = bbox_valid_q;
  assign obj_found  = obj_found_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_bin_bbox_detector.sv
// tb/tb_bin_bbox_detector.sv - scoreboard bench for bin_bbox_detector on an 8x6 frame (BBOX_BORDER_MASK_EN)
module tb_bin_bbox_detector;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 6;
  localparam int X_W     = 11;
  localparam int Y_W     = 10;
  localparam int PC_W    = 19;
  localparam int MIN_PIX = 4;
  localparam int BORDER  = 1;

  typedef struct packed {
    logic            obj;
    logic [X_W-1:0]  xmin;
    logic [X_W-1:0]  xmax;
    logic [Y_W-1:0]  ymin;
    logic [Y_W-1:0]  ymax;
    logic [PC_W-1:0] cnt;
  } res_t;

  logic pixelclk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic vs = 1'b0;
  logic hs = 1'b0;
  logic ck = 1'b0;
  logic pb = 1'b0;
  logic            bbox_valid, obj_found;
  logic [X_W-1:0]  x_min, x_max;
  logic [Y_W-1:0]  y_min, y_max;
  logic [PC_W-1:0] pix_cnt;

  res_t exp_q[$];
  res_t last_res;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   fg_map[0:IMG_H-1][0:9];

  always #5 pixelclk = ~pixelclk;

  bin_bbox_detector #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W),
    .PC_W(PC_W), .MIN_PIX(MIN_PIX), .BORDER(BORDER)
  ) dut (
    .pixelclk(pixelclk), .rst(rst), .en(en),
    .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ck), .per_img_Bit(pb),
    .bbox_valid(bbox_valid), .obj_found(obj_found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .pix_cnt(pix_cnt)
  );

  function automatic res_t observed();
    return {obj_found, x_min, x_max, y_min, y_max, pix_cnt};
  endfunction

  function automatic bit masked(int c, int r);
`ifdef BBOX_BORDER_MASK_EN
    return (c < BORDER) || (c > IMG_W - 1 - BORDER) || (r < BORDER) || (r > IMG_H - 1 - BORDER);
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_map(input bit v);
    for (int r = 0; r < IMG_H; r++)
      for (int i = 0; i < 10; i++) fg_map[r][i] = v;
  endtask

  task automatic set_basic(input bit fourth);
    fill_map(1'b0);
    fg_map[1][2] = 1'b1;
    fg_map[1][5] = 1'b1;
    fg_map[4][3] = 1'b1;
    fg_map[4][4] = fourth;
  endtask

  // Drive one frame of len clken pixels per line; the model result goes to the scoreboard if enabled
  task automatic send_frame(input bit en_v, input int len);
    int cnt, xmn, xmx, ymn, ymx, c;
    res_t e;
    cnt = 0; xmn = IMG_W; xmx = -1; ymn = IMG_H; ymx = -1;
    @(negedge pixelclk);
    en = en_v;
    vs = 1'b1;
    repeat (2) @(negedge pixelclk);
    for (int r = 0; r < IMG_H; r++) begin
      for (int i = 0; i < len; i++) begin
        hs = 1'b1; ck = 1'b1; pb = fg_map[r][i];
        c = (i > IMG_W - 1) ? IMG_W - 1 : i;
        if (fg_map[r][i] && !masked(c, r)) begin
          cnt++;
          if (c < xmn) xmn = c;
          if (c > xmx) xmx = c;
          if (r < ymn) ymn = r;
          if (r > ymx) ymx = r;
        end
        @(negedge pixelclk);
      end
      hs = 1'b0; ck = 1'b0; pb = 1'b0;
      repeat (3) @(negedge pixelclk);
    end
    vs = 1'b0;
    if (en_v) begin
      if (cnt >= MIN_PIX) e = '{1'b1, X_W'(xmn), X_W'(xmx), Y_W'(ymn), Y_W'(ymx), PC_W'(cnt)};
      else                e = '{1'b0, '0, '0, '0, '0, PC_W'(cnt)};
      exp_q.push_back(e);
    end
  endtask

  // Watch a bounded window after vsync falls: first strobe latency, strobe count, data at strobe
  task automatic wait_strobe(output int lat, output int n, output res_t obs);
    lat = 0; n = 0; obs = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge pixelclk);
      if (bbox_valid) begin
        n++;
        if (lat == 0) begin
          lat = k;
          obs = observed();
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pixelclk);
    n_checks++; if (bbox_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bbox_valid got %0b want 0", bbox_valid); end
    n_checks++; if (observed() !== res_t'(0)) begin n_fail++; $display("FAIL reset_outputs got %h want 0", observed()); end
    rst = 1'b0;
    repeat (2) @(negedge pixelclk);
    n_checks++; if (bbox_valid !== 1'b0) begin n_fail++; $display("FAIL idle_bbox_valid got %0b want 0", bbox_valid); end
    last_res = '0;
  endtask

  task automatic test_basic();
    int lat, n; res_t obs, e;
    set_basic(1'b1);
    send_frame(1'b1, IMG_W);
    wait_strobe(lat, n, obs);
    // vsync low is first sampled one edge in, then two more edges to the strobe
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL basic_strobe_count got %0d want 1", n); end
    e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL basic_result got %h want %h", obs, e); end
    n_checks++; if (obs !== res_t'{1'b1, 11'd2, 11'd5, 10'd1, 10'd4, 19'd4}) begin n_fail++; $display("FAIL basic_const got %h", obs); end
    n_checks++; if (observed() !== e) begin n_fail++; $display("FAIL basic_hold got %h want %h", observed(), e); end
    last_res = e;
  endtask

  task automatic test_below_min();
    int lat, n; res_t obs, e;
    set_basic(1'b0);
    send_frame(1'b1, IMG_W);
    wait_strobe(lat, n, obs);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL below_strobe_count got %0d want 1", n); end
    e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL below_result got %h want %h", obs, e); end
    n_checks++; if (obs !== res_t'{1'b0, 11'd0, 11'd0, 10'd0, 10'd0, 19'd3}) begin n_fail++; $display("FAIL below_const got %h", obs); end
    last_res = e;
  endtask

  task automatic test_enable();
    int lat, n; res_t obs, e;
    fill_map(1'b1);
    send_frame(1'b0, IMG_W);
    wait_strobe(lat, n, obs);
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL disabled_strobe got %0d want 0", n); end
    n_checks++; if (observed() !== last_res) begin n_fail++; $display("FAIL disabled_hold got %h want %h", observed(), last_res); end
    set_basic(1'b1);
    send_frame(1'b1, IMG_W);
    wait_strobe(lat, n, obs);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL reenable_strobe got %0d want 1", n); end
    e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reenable_result got %h want %h", obs, e); end
    last_res = e;
  endtask

  task automatic test_reset_mid();
    int lat, n; res_t obs, e;
    @(negedge pixelclk);
    en = 1'b1; vs = 1'b1;
    repeat (2) @(negedge pixelclk);
    for (int i = 0; i < IMG_W; i++) begin hs = 1'b1; ck = 1'b1; pb = 1'b1; @(negedge pixelclk); end
    hs = 1'b0; ck = 1'b0; pb = 1'b0;
    repeat (3) @(negedge pixelclk);
    for (int i = 0; i < 2; i++) begin hs = 1'b1; ck = 1'b1; pb = 1'b1; @(negedge pixelclk); end
    hs = 1'b0; ck = 1'b0; pb = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (observed() !== res_t'(0)) begin n_fail++; $display("FAIL midreset_clear got %h want 0", observed()); end
    @(negedge pixelclk);
    rst = 1'b0;
    repeat (4) @(negedge pixelclk);
    vs = 1'b0;
    wait_strobe(lat, n, obs);
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL midreset_strobe got %0d want 0", n); end
    last_res = '0;
    set_basic(1'b1);
    send_frame(1'b1, IMG_W);
    wait_strobe(lat, n, obs);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL after_reset_latency got %0d want 3", lat); end
    e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL after_reset_result got %h want %h", obs, e); end
    last_res = e;
  endtask

  task automatic test_full();
    int lat, n; res_t obs, e, k;
`ifdef BBOX_BORDER_MASK_EN
    k = '{1'b1, 11'd1, 11'd6, 10'd1, 10'd4, 19'd24};
`else
    k = '{1'b1, 11'd0, 11'd7, 10'd0, 10'd5, 19'd48};
`endif
    fill_map(1'b1);
    send_frame(1'b1, IMG_W);
    wait_strobe(lat, n, obs);
    e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL full_result got %h want %h", obs, e); end
    n_checks++; if (obs !== k) begin n_fail++; $display("FAIL full_const got %h want %h", obs, k); end
    last_res = e;
  endtask

  task automatic test_long_line();
    int lat, n; res_t obs, e, k;
`ifdef BBOX_BORDER_MASK_EN
    k = '{1'b0, 11'd0, 11'd0, 10'd0, 10'd0, 19'd0};
`else
    k = '{1'b1, 11'd0, 11'd7, 10'd0, 10'd3, 19'd5};
`endif
    fill_map(1'b0);
    for (int r = 0; r < 4; r++) fg_map[r][9] = 1'b1;
    fg_map[2][0] = 1'b1;
    send_frame(1'b1, 10);
    wait_strobe(lat, n, obs);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL long_strobe_count got %0d want 1", n); end
    e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL long_result got %h want %h", obs, e); end
    n_checks++; if (obs !== k) begin n_fail++; $display("FAIL long_const got %h want %h", obs, k); end
    last_res = e;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_below_min();
    test_enable();
    test_reset_mid();
    test_full();
    test_long_line();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
